// File: rtl/imm_encoder_if.sv
// Request/response bus of the immediate encoder: request side (in_*, ImmSrc, Imm,
// InstrIn) and encoded-word side (out_*, InstrOut). Clock and reset stay outside.
interface imm_encoder_if;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  ImmSrc;
   logic [31:0] Imm;
   logic [31:0] InstrIn;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] InstrOut;
   logic        out_last;
   logic        out_err;

   modport master (
      output in_valid, ImmSrc, Imm, InstrIn, out_ready,
      input  in_ready, out_valid, InstrOut, out_last, out_err
   );

   modport slave (
      input  in_valid, ImmSrc, Imm, InstrIn, out_ready,
      output in_ready, out_valid, InstrOut, out_last, out_err
   );
endinterface

// File: rtl/imm_encoder.sv
// Packs an immediate into a template instruction (I/S/B/J/U) or expands a 32-bit
// constant load into LUI/ADDI. Optional range checking: define IMM_RANGE_CHECK_EN.
module imm_encoder (
   input  logic          clk,
   input  logic          reset,
   imm_encoder_if.slave  bus
);
   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_LI2  = 1'b1
   } state_t;

   localparam logic [6:0] OP_LUI  = 7'b0110111;
   localparam logic [6:0] OP_ADDI = 7'b0010011;

   state_t      state_r;
   state_t      next_state_s;
   logic        out_valid_r;
   logic [31:0] instr_out_r;
   logic        out_last_r;
   logic        out_err_r;
   logic [31:0] pend_r;

   logic        nxt_valid_s;
   logic [31:0] nxt_word_s;
   logic        nxt_last_s;
   logic        nxt_err_s;
   logic [31:0] nxt_pend_s;

   logic        in_ready_s;
   logic        accept_s;
   logic [4:0]  rd_s;
   logic [11:0] lo_s;
   logic [19:0] hi_s;
   logic [31:0] lui_s;
   logic [31:0] addi_x0_s;
   logic [31:0] addi_rd_s;
   logic [31:0] req_word_s;
   logic        req_last_s;
   logic        req_err_s;
   logic        req_two_s;

   function automatic logic [31:0] pack_imm(input logic [2:0] src, input logic [31:0] imm,
                                            input logic [31:0] instr);
      logic [31:0] w;
      w = instr;
      case (src)
         3'b000: w[31:20] = imm[11:0];
         3'b001: begin
            w[31:25] = imm[11:5];
            w[11:7]  = imm[4:0];
         end
         3'b010: begin
            w[31]    = imm[12];
            w[7]     = imm[11];
            w[30:25] = imm[10:5];
            w[11:8]  = imm[4:1];
         end
         3'b011: begin
            w[31]    = imm[20];
            w[30:21] = imm[10:1];
            w[20]    = imm[11];
            w[19:12] = imm[19:12];
         end
         3'b100: w[31:12] = imm[31:12];
         default: w = instr;
      endcase
      return w;
   endfunction

`ifdef IMM_RANGE_CHECK_EN
   function automatic logic imm_err(input logic [2:0] src, input logic [31:0] imm);
      logic e;
      case (src)
         3'b000, 3'b001: e = (imm != {{20{imm[11]}}, imm[11:0]});
         3'b010:         e = (imm != {{19{imm[12]}}, imm[12:0]}) || imm[0];
         3'b011:         e = (imm != {{11{imm[20]}}, imm[20:0]}) || imm[0];
         3'b100:         e = (imm[11:0] != 12'd0);
         3'b101:         e = 1'b0;
         default:        e = 1'b1;
      endcase
      return e;
   endfunction
`else
   function automatic logic imm_err(input logic [2:0] src);
      return (src[2:1] == 2'b11);
   endfunction
`endif

   // LI building blocks; hi is (Imm + 0x800) >> 12 computed without the unused low sum bits
   always_comb begin
      rd_s      = bus.InstrIn[11:7];
      lo_s      = bus.Imm[11:0];
      hi_s      = bus.Imm[31:12] + {19'd0, bus.Imm[11]};
      lui_s     = {hi_s, rd_s, OP_LUI};
      addi_x0_s = {lo_s, 5'd0, 3'b000, rd_s, OP_ADDI};
      addi_rd_s = {lo_s, rd_s, 3'b000, rd_s, OP_ADDI};
   end

   // First output word and flags for the request currently on the bus
   always_comb begin
      req_word_s = bus.InstrIn;
      req_last_s = 1'b1;
      req_err_s  = 1'b0;
      req_two_s  = 1'b0;
      if (bus.ImmSrc == 3'b101) begin
         if (hi_s == 20'd0) begin
            req_word_s = addi_x0_s;
         end else if (lo_s == 12'd0) begin
            req_word_s = lui_s;
         end else begin
            req_word_s = lui_s;
            req_last_s = 1'b0;
            req_two_s  = 1'b1;
         end
      end else begin
         req_word_s = pack_imm(bus.ImmSrc, bus.Imm, bus.InstrIn);
`ifdef IMM_RANGE_CHECK_EN
         req_err_s  = imm_err(bus.ImmSrc, bus.Imm);
`else
         req_err_s  = imm_err(bus.ImmSrc);
`endif
      end
   end

   // Next-state and output-register load decisions
   always_comb begin
      next_state_s = state_r;
      nxt_valid_s  = out_valid_r;
      nxt_word_s   = instr_out_r;
      nxt_last_s   = out_last_r;
      nxt_err_s    = out_err_r;
      nxt_pend_s   = pend_r;
      in_ready_s   = (state_r == ST_IDLE) && (!out_valid_r || bus.out_ready);
      accept_s     = bus.in_valid && in_ready_s;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               nxt_valid_s = 1'b1;
               nxt_word_s  = req_word_s;
               nxt_last_s  = req_last_s;
               nxt_err_s   = req_err_s;
               nxt_pend_s  = addi_rd_s;
               if (req_two_s) begin
                  next_state_s = ST_LI2;
               end else begin
                  next_state_s = ST_IDLE;
               end
            end else if (bus.out_ready) begin
               nxt_valid_s = 1'b0;
            end else begin
               nxt_valid_s = out_valid_r;
            end
         end
         ST_LI2: begin
            if (bus.out_ready) begin
               nxt_valid_s  = 1'b1;
               nxt_word_s   = pend_r;
               nxt_last_s   = 1'b1;
               nxt_err_s    = 1'b0;
               next_state_s = ST_IDLE;
            end else begin
               next_state_s = ST_LI2;
            end
         end
         default: begin
            next_state_s = ST_IDLE;
            nxt_valid_s  = 1'b0;
         end
      endcase
   end

   // State and output registers; reset drops any pending ADDI word
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= ST_IDLE;
         out_valid_r <= 1'b0;
         instr_out_r <= 32'd0;
         out_last_r  <= 1'b0;
         out_err_r   <= 1'b0;
         pend_r      <= 32'd0;
      end else begin
         state_r     <= next_state_s;
         out_valid_r <= nxt_valid_s;
         instr_out_r <= nxt_word_s;
         out_last_r  <= nxt_last_s;
         out_err_r   <= nxt_err_s;
         pend_r      <= nxt_pend_s;
      end
   end

   assign bus.in_ready  = in_ready_s;
   assign bus.out_valid = out_valid_r;
   assign bus.InstrOut  = instr_out_r;
   assign bus.out_last  = out_last_r;
   assign bus.out_err   = out_err_r;
endmodule

// File: tb/tb_imm_encoder.sv
// Scoreboard bench for imm_encoder: directed requests push expected words, a
// negedge monitor pops and compares every word the consumer accepts.
module tb_imm_encoder;
   typedef struct packed {
      logic [31:0] word;
      logic        last;
      logic        err;
   } exp_t;

`ifdef IMM_RANGE_CHECK_EN
   localparam logic RC = 1'b1;
`else
   localparam logic RC = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   failures = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   imm_encoder_if bus();
   imm_encoder dut (.clk(clk), .reset(reset), .bus(bus));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%08h expected=%08h", name, act, exp);
      end
   endtask

   task automatic expect_word(input logic [31:0] w, input logic l, input logic e);
      sb.push_back('{word: w, last: l, err: e});
   endtask

   task automatic send(input logic [2:0] src, input logic [31:0] imm, input logic [31:0] instr);
      bit done = 1'b0;
      bus.in_valid = 1'b1;
      bus.ImmSrc   = src;
      bus.Imm      = imm;
      bus.InstrIn  = instr;
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge clk);
         done = bus.in_ready;
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b0;
      if (!done) begin
         checks++;
         failures++;
         $display("FAIL accept_timeout actual=no_accept expected=accept");
      end else begin
         chk("latency_valid", {31'd0, bus.out_valid}, 32'd1);
      end
   endtask

   // Monitor: every word transferred to the consumer must match the scoreboard head
   always @(negedge clk) begin
      exp_t e;
      if (!reset && bus.out_valid && bus.out_ready) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_output actual=%08h expected=none", bus.InstrOut);
         end else begin
            e = sb.pop_front();
            chk("sb_word", bus.InstrOut, e.word);
            chk("sb_last", {31'd0, bus.out_last}, {31'd0, e.last});
            chk("sb_err",  {31'd0, bus.out_err},  {31'd0, e.err});
         end
      end
   end

   initial begin
      reset        = 1'b1;
      bus.in_valid = 1'b0;
      bus.ImmSrc   = 3'b000;
      bus.Imm      = 32'd0;
      bus.InstrIn  = 32'd0;
      bus.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("rst_instr_out", bus.InstrOut, 32'd0);
      chk("rst_out_last",  {31'd0, bus.out_last}, 32'd0);
      chk("rst_out_err",   {31'd0, bus.out_err},  32'd0);
      chk("rst_in_ready",  {31'd0, bus.in_ready}, 32'd1);

      bus.out_ready = 1'b1;
      expect_word(32'hFFB00093, 1'b1, 1'b0);
      send(3'b000, 32'hFFFFFFFB, 32'h00000093);
      expect_word(32'h0020A423, 1'b1, 1'b0);
      send(3'b001, 32'h00000008, 32'h0020A023);
      expect_word(32'hFE000EE3, 1'b1, 1'b0);
      send(3'b010, 32'hFFFFFFFC, 32'h00000063);
      expect_word(32'h001000EF, 1'b1, 1'b0);
      send(3'b011, 32'h00000800, 32'h000000EF);
      expect_word(32'h12345537, 1'b1, 1'b0);
      send(3'b100, 32'h12345000, 32'h00000537);
      expect_word(32'h12345678, 1'b1, 1'b1);
      send(3'b110, 32'h0000FFFF, 32'h12345678);
      expect_word(32'h80000093, 1'b1, RC);
      send(3'b000, 32'h00000800, 32'h00000093);
      expect_word(32'h00000163, 1'b1, RC);
      send(3'b010, 32'h00000003, 32'h00000063);

      expect_word(32'h123462B7, 1'b0, 1'b0);
      expect_word(32'hFFF28293, 1'b1, 1'b0);
      send(3'b101, 32'h12345FFF, 32'h00000280);
      chk("li2_in_ready", {31'd0, bus.in_ready}, 32'd0);
      expect_word(32'h7FF00293, 1'b1, 1'b0);
      send(3'b101, 32'h000007FF, 32'h00000280);
      expect_word(32'h000122B7, 1'b1, 1'b0);
      send(3'b101, 32'h00012000, 32'h00000280);

      for (int i = 0; i < 50 && sb.size() != 0; i++) begin
         @(posedge clk);
         #1;
      end
      chk("drain_empty", sb.size(), 32'd0);

      // Backpressure in LI2, then reset drops the pending ADDI
      repeat (3) @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      send(3'b101, 32'h12345FFF, 32'h00000280);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         chk("hold_word",  bus.InstrOut, 32'h123462B7);
         chk("hold_valid", {31'd0, bus.out_valid}, 32'd1);
      end
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("reset_li2_valid",    {31'd0, bus.out_valid}, 32'd0);
      chk("reset_li2_in_ready", {31'd0, bus.in_ready},  32'd1);
      reset = 1'b0;
      bus.out_ready = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      chk("no_addi_after_reset", {31'd0, bus.out_valid}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
